// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : shared constants, FSM state type and pixel addressing for framebuffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  localparam int FB_WIDTH         = 256;
  localparam int FB_HEIGHT        = 64;
  localparam int FB_BYTES_PER_ROW = 128;
  localparam int FB_DEPTH         = 8192;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_PIXEL = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RMW  = 2'd1,
    FILL = 2'd2
  } fb_state_t;

  // Two 4 bpp pixels per byte, 128 bytes per row.
  function automatic logic [12:0] pixel_byte_addr(input logic [7:0] x, input logic [5:0] y);
    return {y, x[7:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_ram.sv
// ---------------------------------------------------------------------------
// fb_ram : true dual-port synchronous byte RAM; port A read-only, port B read-first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_ram #(
  parameter     MEM_INIT_FILE = "",
  parameter int DEPTH         = 8192,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_data,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (b_en && b_we) mem[b_addr] <= b_wdata;
  end

  // Output registers reset; the array itself never is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data  <= 8'h00;
      b_rdata <= 8'h00;
    end else begin
      if (a_en) a_data  <= mem[a_addr];
      if (b_en) b_rdata <= mem[b_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/framebuffer.sv
// ---------------------------------------------------------------------------
// framebuffer : 256x64 4 bpp dual-port framebuffer with host write/read/pixel/fill
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module framebuffer
  import fb_pkg::*;
#(
  parameter     MEM_INIT_FILE = "",
  parameter int DEPTH         = FB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_re,
  input  logic [12:0] pixel_addr,
  output logic [7:0]  pixel_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_x,
  input  logic [5:0]  req_y,
  input  logic [7:0]  req_data,
  input  logic [13:0] req_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  fb_state_t   state, state_nxt;
  logic [12:0] op_addr;
  logic [13:0] fill_left;
  logic [7:0]  op_data;
  logic        pix_lo;
  logic [7:0]  rsp_hold;
  logic        accept;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;

  // Port B register also captures RMW/write reads, so the last read reply is held separately.
  assign rsp_data  = rsp_valid ? ram_rdata : rsp_hold;

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr;
    ram_wdata = req_data;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_WRITE: begin
              ram_en = 1'b1;
              ram_we = 1'b1;
            end
            OP_READ: ram_en = 1'b1;
            OP_PIXEL: begin
              ram_en    = 1'b1;
              ram_addr  = pixel_byte_addr(req_x, req_y);
              state_nxt = RMW;
            end
            OP_FILL: if (req_len != 14'd0) state_nxt = FILL;
          endcase
        end
      end
      RMW: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = op_addr;
        ram_wdata = pix_lo ? {ram_rdata[7:4], op_data[3:0]} : {op_data[3:0], ram_rdata[3:0]};
        state_nxt = IDLE;
      end
      FILL: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = op_addr;
        ram_wdata = op_data;
        if (fill_left == 14'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_hold  <= 8'h00;
      op_addr   <= 13'd0;
      fill_left <= 14'd0;
      op_data   <= 8'h00;
      pix_lo    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= accept && (req_op == OP_READ);
      if (rsp_valid) rsp_hold <= ram_rdata;
      if (accept) begin
        op_data   <= req_data;
        pix_lo    <= req_x[0];
        op_addr   <= (req_op == OP_PIXEL) ? pixel_byte_addr(req_x, req_y) : req_addr;
        fill_left <= req_len;
      end else if (state == FILL) begin
        op_addr   <= op_addr + 13'd1;
        fill_left <= fill_left - 14'd1;
      end
    end
  end

  fb_ram #(
    .MEM_INIT_FILE (MEM_INIT_FILE),
    .DEPTH         (DEPTH),
    .AW            (13)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_en    (pixel_re),
    .a_addr  (pixel_addr),
    .a_data  (pixel_data),
    .b_en    (ram_en),
    .b_we    (ram_we),
    .b_addr  (ram_addr),
    .b_wdata (ram_wdata),
    .b_rdata (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_framebuffer : self-checking bench for framebuffer with a read-response scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_framebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_re = 1'b0;
  logic [12:0] pixel_addr = '0;
  logic [7:0]  pixel_data;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_x = '0;
  logic [5:0]  req_y = '0;
  logic [7:0]  req_data = '0;
  logic [13:0] req_len = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [8192];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  framebuffer dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_re   (pixel_re),
    .pixel_addr (pixel_addr),
    .pixel_data (pixel_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_data   (req_data),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [12:0] addr, input logic [7:0] x,
                        input logic [5:0] y, input logic [7:0] data, input logic [13:0] len);
    int n = 0;
    while (!req_ready && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10000) check("ready_timeout", 0, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_x = x; req_y = y;
    req_data = data; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_byte(input logic [12:0] a, input logic [7:0] d);
    do_req(2'd0, a, 8'd0, 6'd0, d, 14'd0);
    model[a] = d;
  endtask

  task automatic rd_byte(input logic [12:0] a);
    exp_q.push_back(model[a]);
    do_req(2'd3, a, 8'd0, 6'd0, 8'd0, 14'd0);
    check("rsp_latency", rsp_valid, 1);
  endtask

  task automatic pix_wr(input logic [7:0] x, input logic [5:0] y, input logic [3:0] c);
    logic [12:0] a;
    a = {y, x[7:1]};
    if (x[0]) model[a][3:0] = c;
    else      model[a][7:4] = c;
    do_req(2'd1, 13'd0, x, y, {4'h0, c}, 14'd0);
    check("pix_ready_low", req_ready, 0);
    check("pix_busy", busy, 1);
    @(posedge clk); #1;
    check("pix_ready_back", req_ready, 1);
  endtask

  task automatic fill(input logic [12:0] a, input logic [13:0] len, input logic [7:0] v);
    int cnt = 0;
    do_req(2'd2, a, 8'd0, 6'd0, v, len);
    while (busy && cnt < 9000) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("fill_busy_cycles", cnt, len);
    for (int i = 0; i < len; i++) model[13'(a + 13'(i))] = v;
  endtask

  task automatic disp_rd(input logic [12:0] a);
    pixel_re = 1'b1; pixel_addr = a;
    @(posedge clk); #1;
    pixel_re = 1'b0;
    check("disp_data", pixel_data, model[a]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_pixel_data", pixel_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-range fill gives the model known contents.
    fill(13'd0, 14'd8192, 8'h00);

    wr_byte(13'h0010, 8'hA5);
    rd_byte(13'h0010);
    @(posedge clk); #1;
    check("rsp_pulse_width", rsp_valid, 0);
    check("rsp_hold", rsp_data, 8'hA5);
    disp_rd(13'h0010);

    wr_byte(13'h0081, 8'h00);
    pix_wr(8'd2, 6'd1, 4'h7);
    pix_wr(8'd3, 6'd1, 4'hC);
    rd_byte(13'h0081);
    check("pix_model", model[13'h0081], 8'h7C);
    pix_wr(8'd255, 6'd63, 4'h9);
    pix_wr(8'd0, 6'd63, 4'h3);
    rd_byte(13'h1FFF);
    rd_byte(13'h1F80);

    for (int i = 0; i < 4; i++) wr_byte(13'(13'h0200 + 13'(i)), 8'(8'h11 * (i + 1)));
    for (int i = 3; i >= 0; i--) rd_byte(13'(13'h0200 + 13'(i)));
    wr_byte(13'h0020, 8'h5A);
    rd_byte(13'h0020);

    wr_byte(13'h0002, 8'h11);
    fill(13'h1FFE, 14'd4, 8'h3C);
    rd_byte(13'h1FFE);
    rd_byte(13'h1FFF);
    rd_byte(13'h0000);
    rd_byte(13'h0001);
    rd_byte(13'h0002);
    fill(13'h0100, 14'd0, 8'hEE);
    check("fill0_busy", busy, 0);
    rd_byte(13'h0100);

    // Display scan racing a full fill: each read collides with the write to the same byte.
    begin
      int cnt = 0;
      int bad = 0;
      do_req(2'd2, 13'd0, 8'd0, 6'd0, 8'hFF, 14'd8192);
      for (int i = 0; i < 8192; i++) begin
        pixel_re = 1'b1; pixel_addr = 13'(i);
        @(posedge clk); #1;
        if (pixel_data !== model[i]) bad++;
      end
      pixel_re = 1'b0;
      check("scan_read_first", bad, 0);
      while (busy && cnt < 100) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("big_fill_done", busy, 0);
      for (int i = 0; i < 8192; i++) model[i] = 8'hFF;
      bad = 0;
      for (int i = 0; i < 8192; i++) begin
        pixel_re = 1'b1; pixel_addr = 13'(i);
        @(posedge clk); #1;
        if (pixel_data !== 8'hFF) bad++;
      end
      pixel_re = 1'b0;
      check("all_ff", bad, 0);
    end

    // Reset after 50 of 100 fill writes.
    do_req(2'd2, 13'h0100, 8'd0, 6'd0, 8'h66, 14'd100);
    pixel_re = 1'b1; pixel_addr = 13'h0100;
    repeat (50) @(posedge clk);
    #1;
    check("midfill_busy", busy, 1);
    check("midfill_pix", pixel_data, 8'h66);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_pixel_data", pixel_data, 0);
    pixel_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) model[13'h0100 + 13'(i)] = 8'h66;
    for (int i = 0; i < 100; i++) rd_byte(13'h0100 + 13'(i));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
